// File: rtl/output_layer_seq.sv
// ---------------------------------------------------------------------------
// output_layer_seq
//   Sequential two-neuron output layer. Four signed hidden-layer values are
//   captured, clamped to unsigned activations, and then multiplied against
//   two static weight columns, one multiply-accumulate per neuron per cycle.
//   The result is the pair of neuron sums plus an argmax class bit.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   input_ready         hidden-layer results valid (accepted only in IDLE)
//   in0..in3            signed hidden-layer results (in_width bits)
//   w48..w78            signed 5-bit weights, hidden 0..3 -> neuron 8
//   w49..w79            signed 5-bit weights, hidden 0..3 -> neuron 9
//   out0, out1          neuron 8 / neuron 9 sums (output_width bits, signed)
//   class_out           1 when out1 > out0, otherwise 0 (a tie gives 0)
//   busy                high whenever the FSM is not in IDLE
//   output_ready        one-cycle pulse when out0/out1/class_out update
//
// Timing: capture edge -> ACT edge -> four MAC edges. output_ready rises on
// the sixth edge counting the capture edge, and the DONE edge returns to
// IDLE, so back-to-back requests are accepted every 7 cycles.
// ---------------------------------------------------------------------------
module output_layer_seq #(
  parameter int in_width     = 12,
  parameter int act_width    = 6,
  parameter int output_width = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           input_ready,
  input  logic signed [in_width-1:0]     in0,
  input  logic signed [in_width-1:0]     in1,
  input  logic signed [in_width-1:0]     in2,
  input  logic signed [in_width-1:0]     in3,
  input  logic signed [4:0]              w48,
  input  logic signed [4:0]              w58,
  input  logic signed [4:0]              w68,
  input  logic signed [4:0]              w78,
  input  logic signed [4:0]              w49,
  input  logic signed [4:0]              w59,
  input  logic signed [4:0]              w69,
  input  logic signed [4:0]              w79,
  output logic signed [output_width-1:0] out0,
  output logic signed [output_width-1:0] out1,
  output logic                           class_out,
  output logic                           busy,
  output logic                           output_ready
);

  // Product of an unsigned act_width value and a signed 5-bit weight needs
  // act_width+5 signed bits; four of them summed need two more.
  localparam int ACC_W = act_width + 7;
  // Common width for saturating the sums into output_width.
  localparam int BIG_W = (output_width > ACC_W) ? output_width : ACC_W;

  localparam logic signed [BIG_W-1:0] OUT_MAX =
    {{(BIG_W-output_width+1){1'b0}}, {(output_width-1){1'b1}}};
  localparam logic signed [BIG_W-1:0] OUT_MIN =
    {{(BIG_W-output_width+1){1'b1}}, {(output_width-1){1'b0}}};
  localparam logic signed [in_width:0] ACT_MAX =
    {{(in_width+1-act_width){1'b0}}, {act_width{1'b1}}};

  typedef enum logic [1:0] {IDLE, ACT, MAC, DONE} state_t;

  state_t                         state_reg;
  logic signed [in_width-1:0]     in_reg [4];
  logic        [act_width-1:0]    act_reg [4];
  logic        [act_width-1:0]    act_next [4];
  logic signed [ACC_W-1:0]        acc8_reg;
  logic signed [ACC_W-1:0]        acc9_reg;
  logic        [1:0]              idx_reg;
  logic signed [output_width-1:0] out0_reg;
  logic signed [output_width-1:0] out1_reg;
  logic                           class_reg;
  logic                           busy_reg;
  logic                           ready_reg;

  // ReLU plus saturation of each captured hidden value.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_act
      logic signed [in_width:0] in_ext;
      assign in_ext = {in_reg[gi][in_width-1], in_reg[gi]};
      assign act_next[gi] = in_reg[gi][in_width-1] ? '0 :
                            (in_ext > ACT_MAX)     ? {act_width{1'b1}} :
                                                     in_reg[gi][act_width-1:0];
    end
  endgenerate

  // Operand selection for the current MAC index.
  logic        [act_width-1:0] act_k;
  logic signed [4:0]           w8_k;
  logic signed [4:0]           w9_k;

  always_comb begin
    act_k = act_reg[idx_reg];
    w8_k  = w48;
    w9_k  = w49;
    case (idx_reg)
      2'd0: begin w8_k = w48; w9_k = w49; end
      2'd1: begin w8_k = w58; w9_k = w59; end
      2'd2: begin w8_k = w68; w9_k = w69; end
      default: begin w8_k = w78; w9_k = w79; end
    endcase
  end

  // Activation is zero-extended, weights sign-extended, so the signed
  // multiply at ACC_W bits gives the exact product.
  logic signed [ACC_W-1:0] act_ext;
  logic signed [ACC_W-1:0] w8_ext;
  logic signed [ACC_W-1:0] w9_ext;
  logic signed [ACC_W-1:0] sum8_next;
  logic signed [ACC_W-1:0] sum9_next;
  logic signed [BIG_W-1:0] sum8_big;
  logic signed [BIG_W-1:0] sum9_big;
  logic signed [output_width-1:0] res8_next;
  logic signed [output_width-1:0] res9_next;

  assign act_ext   = {{(ACC_W-act_width){1'b0}}, act_k};
  assign w8_ext    = {{(ACC_W-5){w8_k[4]}}, w8_k};
  assign w9_ext    = {{(ACC_W-5){w9_k[4]}}, w9_k};
  assign sum8_next = acc8_reg + act_ext * w8_ext;
  assign sum9_next = acc9_reg + act_ext * w9_ext;
  assign sum8_big  = BIG_W'(sum8_next);
  assign sum9_big  = BIG_W'(sum9_next);

  function automatic logic signed [output_width-1:0] clip(
    input logic signed [BIG_W-1:0] v
  );
    logic signed [BIG_W-1:0] c;
    c = v;
    if (v > OUT_MAX) c = OUT_MAX;
    if (v < OUT_MIN) c = OUT_MIN;
    return c[output_width-1:0];
  endfunction

  assign res8_next = clip(sum8_big);
  assign res9_next = clip(sum9_big);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      for (int i = 0; i < 4; i++) begin
        in_reg[i]  <= '0;
        act_reg[i] <= '0;
      end
      acc8_reg  <= '0;
      acc9_reg  <= '0;
      idx_reg   <= '0;
      out0_reg  <= '0;
      out1_reg  <= '0;
      class_reg <= 1'b0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (input_ready) begin
            in_reg[0] <= in0;
            in_reg[1] <= in1;
            in_reg[2] <= in2;
            in_reg[3] <= in3;
            busy_reg  <= 1'b1;
            state_reg <= ACT;
          end
        end
        ACT: begin
          for (int i = 0; i < 4; i++) act_reg[i] <= act_next[i];
          acc8_reg  <= '0;
          acc9_reg  <= '0;
          idx_reg   <= '0;
          state_reg <= MAC;
        end
        MAC: begin
          acc8_reg <= sum8_next;
          acc9_reg <= sum9_next;
          idx_reg  <= idx_reg + 2'd1;
          if (idx_reg == 2'd3) begin
            out0_reg  <= res8_next;
            out1_reg  <= res9_next;
            class_reg <= (res9_next > res8_next);
            ready_reg <= 1'b1;
            state_reg <= DONE;
          end
        end
        DONE: begin
          ready_reg <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          ready_reg <= 1'b0;
        end
      endcase
    end
  end

  assign out0         = out0_reg;
  assign out1         = out1_reg;
  assign class_out    = class_reg;
  assign busy         = busy_reg;
  assign output_ready = ready_reg;

endmodule

// File: tb/tb_output_layer_seq.sv
// ---------------------------------------------------------------------------
// tb_output_layer_seq
//   Directed-vector bench for output_layer_seq. The stimulus process pushes
//   hand-computed results (with the expected capture cycle) into a queue;
//   a monitor pops and checks them whenever output_ready is seen, and checks
//   that outputs hold their last expected value between pulses.
// ---------------------------------------------------------------------------
module tb_output_layer_seq;

  logic clk = 1'b0;
  logic rst;
  logic input_ready;
  logic signed [11:0] in0, in1, in2, in3;
  logic signed [4:0]  w48, w58, w68, w78, w49, w59, w69, w79;
  logic signed [15:0] out0, out1;
  logic class_out, busy, output_ready;

  output_layer_seq #(.in_width(12), .act_width(6), .output_width(16)) dut (
    .clk(clk), .rst(rst), .input_ready(input_ready),
    .in0(in0), .in1(in1), .in2(in2), .in3(in3),
    .w48(w48), .w58(w58), .w68(w68), .w78(w78),
    .w49(w49), .w59(w59), .w69(w69), .w79(w79),
    .out0(out0), .out1(out1), .class_out(class_out),
    .busy(busy), .output_ready(output_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int   o0;
    int   o1;
    logic c;
    int   cap;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Monitor / scoreboard
  initial begin : monitor
    int   last0;
    int   last1;
    logic lastc;
    logic prev_ready;
    exp_t e;
    last0 = 0; last1 = 0; lastc = 1'b0; prev_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last0 = 0; last1 = 0; lastc = 1'b0; prev_ready = 1'b0;
      end else if (output_ready) begin
        chk("ready_pulse_width", int'(prev_ready), 0);
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_ready: got output_ready with empty queue (cycle %0d)", cyc);
        end else begin
          e = sb.pop_front();
          chk("out0", int'(out0), e.o0);
          chk("out1", int'(out1), e.o1);
          chk("class_out", int'(class_out), int'(e.c));
          chk("latency", cyc - e.cap, 5);
          last0 = e.o0; last1 = e.o1; lastc = e.c;
        end
        prev_ready = 1'b1;
      end else begin
        chk("hold_out0", int'(out0), last0);
        chk("hold_out1", int'(out1), last1);
        chk("hold_class", int'(class_out), int'(lastc));
        prev_ready = 1'b0;
      end
    end
  end

  task automatic set_w(input int a8, b8, c8, d8, input int a9, b9, c9, d9);
    w48 = 5'(a8); w58 = 5'(b8); w68 = 5'(c8); w78 = 5'(d8);
    w49 = 5'(a9); w59 = 5'(b9); w69 = 5'(c9); w79 = 5'(d9);
  endtask

  task automatic set_in(input int a0, a1, a2, a3);
    in0 = 12'(a0); in1 = 12'(a1); in2 = 12'(a2); in3 = 12'(a3);
  endtask

  task automatic push_exp(input int e0, e1, input logic ec, input int cap);
    exp_t e;
    e.o0 = e0; e.o1 = e1; e.c = ec; e.cap = cap;
    sb.push_back(e);
  endtask

  // Called at a negedge with the DUT idle; capture happens on the next edge.
  task automatic issue(input int a0, a1, a2, a3, input int e0, e1, input logic ec);
    set_in(a0, a1, a2, a3);
    input_ready = 1'b1;
    push_exp(e0, e1, ec, cyc + 1);
    @(negedge clk);
    input_ready = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int c0;
    int busy_low;
    int wait_n;
    rst = 1'b1;
    input_ready = 1'b0;
    set_in(0, 0, 0, 0);
    set_w(0, 0, 0, 0, 0, 0, 0, 0);
    idle(3);
    chk("reset_out0", int'(out0), 0);
    chk("reset_out1", int'(out1), 0);
    chk("reset_class", int'(class_out), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_ready", int'(output_ready), 0);
    rst = 1'b0;
    @(negedge clk);

    // Mixed clamp cases: act=(63,0,30,63)
    set_w(1, 1, 1, 1, -16, 15, 2, -1);
    issue(100, -5, 30, 2047, 156, -1011, 1'b0);
    idle(8);

    // Extreme weights, fully saturated activations
    set_w(-16, -16, -16, -16, 15, 15, 15, 15);
    issue(2047, 2047, 2047, 2047, -4032, 3780, 1'b1);
    idle(8);

    // Zero and negative inputs give a tie at zero
    set_w(5, -3, 7, -16, -16, 15, 2, -1);
    issue(0, 0, 0, 0, 0, 0, 1'b0);
    idle(8);
    issue(-1, -2048, -100, -7, 0, 0, 1'b0);
    idle(8);

    // input_ready held high: captures only in IDLE, one every 7 cycles
    set_w(2, -1, 3, -4, -1, 2, 0, 5);
    set_in(10, 20, -3, 63);
    input_ready = 1'b1;
    c0 = cyc + 1;
    push_exp(-252, 345, 1'b1, c0);
    @(negedge clk);
    set_in(1000, 1000, 1000, 1000);
    busy_low = 0;
    for (int i = 0; i < 21; i++) begin
      if (!busy) busy_low++;
      if (i == 6) begin
        set_in(64, -64, 5, 1);
        push_exp(137, -58, 1'b0, cyc + 1);
      end
      if (i == 7)  set_in(1000, 1000, 1000, 1000);
      if (i == 13) begin
        set_in(7, 7, 7, 7);
        push_exp(0, 42, 1'b1, cyc + 1);
      end
      if (i == 14) begin
        set_in(1000, 1000, 1000, 1000);
        input_ready = 1'b0;
      end
      @(negedge clk);
    end
    chk("busy_low_cycles", busy_low, 3);
    idle(4);

    // Second request during MAC is ignored
    set_w(1, 1, 1, 1, -16, 15, 2, -1);
    issue(100, -5, 30, 2047, 156, -1011, 1'b0);
    idle(2);
    set_in(2047, 2047, 2047, 2047);
    input_ready = 1'b1;
    @(negedge clk);
    input_ready = 1'b0;
    idle(8);

    // Reset during MAC k=2 abandons the operation
    set_w(-16, -16, -16, -16, 15, 15, 15, 15);
    set_in(2047, 2047, 2047, 2047);
    input_ready = 1'b1;
    @(negedge clk);
    input_ready = 1'b0;
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out0", int'(out0), 0);
    chk("midrst_out1", int'(out1), 0);
    chk("midrst_class", int'(class_out), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_ready", int'(output_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    // Request on the first edge after release
    issue(2047, 2047, 2047, 2047, -4032, 3780, 1'b1);
    idle(8);

    wait_n = 0;
    while (sb.size() != 0 && wait_n < 30) begin
      @(negedge clk);
      wait_n++;
    end
    chk("queue_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
